// File: rtl/reaction_round_sequencer.sv
// Reaction-time game round controller: arm, random fore-period, stimulus, result.
// Owns round timing, the target LED, the saturating centisecond score and the best score.
//
// state  | meaning
// IDLE   | one cycle after reset release
// ARM    | LEDs dark, waiting for every switch to be released
// WAIT   | random fore-period; any switch here is a false start
// GO     | target LED lit, score counting ticks
// RESULT | score held, LEDs blink (all-ones on hit, 0101.. on foul)
module reaction_round_sequencer #(
   parameter int NUM_LEDS    = 10,
   parameter int TICK_DIV    = 500000,
   parameter int MIN_WAIT    = 100,
   parameter int RESULT_HOLD = 300,
   parameter int MAX_SCORE   = 9999
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_LEDS-1:0] SW,
   input  logic                clr_best,
   output logic [NUM_LEDS-1:0] LED,
   output logic [13:0]         score,
   output logic [13:0]         best,
   output logic                score_valid,
   output logic                foul,
   output logic [2:0]          phase
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_WAIT   = 3'd2,
      S_GO     = 3'd3,
      S_RESULT = 3'd4
   } state_t;

   localparam int                TW            = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0]     L_TICK_LOAD   = TW'(TICK_DIV - 1);
   localparam logic [15:0]       L_MIN_WAIT    = 16'(MIN_WAIT);
   localparam logic [15:0]       L_RESULT_HOLD = 16'(RESULT_HOLD);
   localparam logic [13:0]       L_MAX_SCORE   = 14'(MAX_SCORE);
   localparam logic [4:0]        L_BLINK_LOAD  = 5'd24;
   localparam logic [NUM_LEDS-1:0] L_ALT       = NUM_LEDS'({NUM_LEDS{2'b01}});
   localparam logic [NUM_LEDS-1:0] L_ALL       = '1;

   state_t              r_state;
   logic [NUM_LEDS-1:0] r_sw_meta;
   logic [NUM_LEDS-1:0] r_sw_s;
   logic [15:0]         r_lfsr;
   logic [TW-1:0]       r_tick_cnt;
   logic [15:0]         r_ticks;
   logic [4:0]          r_blink_cnt;
   logic [15:0]         r_wait_len;
   logic [3:0]          r_target;
   logic [NUM_LEDS-1:0] r_led;
   logic [13:0]         r_score;
   logic [13:0]         r_best;
   logic                r_score_valid;
   logic                r_foul;

   logic                w_tick;
   logic [15:0]         w_ticks_next;
   logic                w_any_sw;
   logic                w_one_sw;
   logic                w_hit;
   logic [NUM_LEDS-1:0] w_target_oh;
   logic [3:0]          w_target_new;
   logic [13:0]         w_score_next;
   logic                w_lfsr_fb;

   assign w_tick       = (r_tick_cnt == '0);
   assign w_ticks_next = r_ticks + 16'd1;
   assign w_any_sw     = (r_sw_s != '0);
   assign w_one_sw     = w_any_sw && ((r_sw_s & (r_sw_s - NUM_LEDS'(1))) == '0);
   assign w_target_oh  = NUM_LEDS'(1) << r_target;
   assign w_hit        = ((r_sw_s & w_target_oh) != '0) && w_one_sw;
   assign w_target_new = 4'(32'(r_lfsr[11:8]) % NUM_LEDS);
   assign w_lfsr_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
   // a switch landing on a tick edge counts that tick
   assign w_score_next = (w_tick && r_score != L_MAX_SCORE) ? r_score + 14'd1 : r_score;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sw_meta <= '0;
         r_sw_s    <= '0;
         r_lfsr    <= 16'hACE1;
      end else begin
         r_sw_meta <= SW;
         r_sw_s    <= r_sw_meta;
         r_lfsr    <= {w_lfsr_fb, r_lfsr[15:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_tick_cnt    <= L_TICK_LOAD;
         r_ticks       <= '0;
         r_blink_cnt   <= L_BLINK_LOAD;
         r_wait_len    <= '0;
         r_target      <= '0;
         r_led         <= '0;
         r_score       <= '0;
         r_best        <= L_MAX_SCORE;
         r_score_valid <= 1'b0;
         r_foul        <= 1'b0;
      end else begin
         r_score_valid <= 1'b0;
         if (w_tick) begin
            r_tick_cnt <= L_TICK_LOAD;
            r_ticks    <= w_ticks_next;
         end else begin
            r_tick_cnt <= r_tick_cnt - TW'(1);
         end
         if (r_state != S_RESULT) r_blink_cnt <= L_BLINK_LOAD;

         // every transition below also restarts the tick timers
         case (r_state)
            S_IDLE: begin
               r_state    <= S_ARM;
               r_tick_cnt <= L_TICK_LOAD;
               r_ticks    <= '0;
            end
            S_ARM: begin
               if (!w_any_sw) begin
                  r_state    <= S_WAIT;
                  r_wait_len <= L_MIN_WAIT + {8'd0, r_lfsr[7:0]};
                  r_target   <= w_target_new;
                  r_tick_cnt <= L_TICK_LOAD;
                  r_ticks    <= '0;
               end
            end
            S_WAIT: begin
               if (w_any_sw) begin
                  r_state       <= S_RESULT;
                  r_foul        <= 1'b1;
                  r_score       <= L_MAX_SCORE;
                  r_score_valid <= 1'b1;
                  r_led         <= L_ALT;
                  r_tick_cnt    <= L_TICK_LOAD;
                  r_ticks       <= '0;
               end else if (w_tick && w_ticks_next == r_wait_len) begin
                  r_state    <= S_GO;
                  r_score    <= '0;
                  r_led      <= w_target_oh;
                  r_tick_cnt <= L_TICK_LOAD;
                  r_ticks    <= '0;
               end
            end
            S_GO: begin
               if (w_hit) begin
                  r_state       <= S_RESULT;
                  r_foul        <= 1'b0;
                  r_score       <= w_score_next;
                  r_score_valid <= 1'b1;
                  r_led         <= L_ALL;
                  r_tick_cnt    <= L_TICK_LOAD;
                  r_ticks       <= '0;
                  if (w_score_next < r_best) r_best <= w_score_next;
               end else if (w_any_sw || w_score_next == L_MAX_SCORE) begin
                  r_state       <= S_RESULT;
                  r_foul        <= 1'b1;
                  r_score       <= L_MAX_SCORE;
                  r_score_valid <= 1'b1;
                  r_led         <= L_ALT;
                  r_tick_cnt    <= L_TICK_LOAD;
                  r_ticks       <= '0;
               end else begin
                  r_score <= w_score_next;
               end
            end
            S_RESULT: begin
               if (w_tick) begin
                  if (w_ticks_next == L_RESULT_HOLD) begin
                     r_state    <= S_ARM;
                     r_foul     <= 1'b0;
                     r_led      <= '0;
                     r_tick_cnt <= L_TICK_LOAD;
                     r_ticks    <= '0;
                  end else if (r_blink_cnt == '0) begin
                     r_blink_cnt <= L_BLINK_LOAD;
                     r_led       <= ~r_led;
                  end else begin
                     r_blink_cnt <= r_blink_cnt - 5'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // clear has priority over a coincident best-score improvement
         if (clr_best) r_best <= L_MAX_SCORE;
      end
   end

   assign LED         = r_led;
   assign score       = r_score;
   assign best        = r_best;
   assign score_valid = r_score_valid;
   assign foul        = r_foul;
   assign phase       = r_state;

endmodule

// File: tb/tb_reaction_round_sequencer.sv
// Bench for reaction_round_sequencer: round-level timing model checked every cycle,
// plus directed rounds with hand-computed scores.
module tb_reaction_round_sequencer;
   localparam int N     = 10;
   localparam int TD    = 4;
   localparam int MINW  = 2;
   localparam int RH    = 60;
   localparam int MAXS  = 9999;
   localparam int L_ALL = (1 << N) - 1;
   localparam int L_ALT = 32'h5555_5555 & L_ALL;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clr_best = 1'b0;
   logic [N-1:0] SW = '0;
   logic [N-1:0] LED;
   logic [13:0]  score, best;
   logic         score_valid, foul;
   logic [2:0]   phase;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   reaction_round_sequencer #(
      .NUM_LEDS(N), .TICK_DIV(TD), .MIN_WAIT(MINW), .RESULT_HOLD(RH), .MAX_SCORE(MAXS)
   ) dut (
      .clk(clk), .reset(rst_n), .SW(SW), .clr_best(clr_best),
      .LED(LED), .score(score), .best(best), .score_valid(score_valid),
      .foul(foul), .phase(phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Round model: each phase is described by cycles spent in it (m_k) and ticks elapsed.
   int m_ph, m_k, m_wl, m_tg, m_score, m_best, m_foul, m_valid, m_led, m_lfsr, m_sw_m, m_sw_s;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = 0; m_k = 0; m_wl = 0; m_tg = 0; m_score = 0; m_best = MAXS;
         m_foul = 0; m_valid = 0; m_led = 0; m_lfsr = 'hACE1; m_sw_m = 0; m_sw_s = 0;
      end else begin
         int nt, nxt, s_now, fb;
         bit tk;
         nt  = (m_k + 1) / TD;
         tk  = ((m_k + 1) % TD) == 0;
         nxt = m_ph;
         m_valid = 0;
         case (m_ph)
            0: nxt = 1;
            1: if (m_sw_s == 0) begin
                  m_wl = MINW + (m_lfsr & 255);
                  m_tg = ((m_lfsr >> 8) & 15) % N;
                  nxt  = 2;
               end
            2: if (m_sw_s != 0) begin
                  m_score = MAXS; m_foul = 1; m_valid = 1; nxt = 4;
               end else if (tk && nt == m_wl) begin
                  m_score = 0; nxt = 3;
               end
            3: begin
                  s_now = (nt < MAXS) ? nt : MAXS;
                  if (m_sw_s == (1 << m_tg)) begin
                     m_score = s_now; m_foul = 0; m_valid = 1; nxt = 4;
                     if (s_now < m_best) m_best = s_now;
                  end else if (m_sw_s != 0) begin
                     m_score = MAXS; m_foul = 1; m_valid = 1; nxt = 4;
                  end else begin
                     m_score = s_now;
                     if (s_now == MAXS) begin m_foul = 1; m_valid = 1; nxt = 4; end
                  end
               end
            4: if (tk && nt == RH) begin m_foul = 0; nxt = 1; end
            default: nxt = 0;
         endcase
         if (clr_best) m_best = MAXS;
         m_k  = (nxt != m_ph) ? 0 : m_k + 1;
         m_ph = nxt;
         case (m_ph)
            3: m_led = 1 << m_tg;
            4: begin
                  m_led = m_foul ? L_ALT : L_ALL;
                  if (((m_k / TD) / 25) % 2 == 1) m_led = m_led ^ L_ALL;
               end
            default: m_led = 0;
         endcase
         fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
         m_lfsr = (m_lfsr >> 1) | (fb << 15);
         m_sw_s = m_sw_m;
         m_sw_m = int'(SW);
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         check("phase", int'(phase), m_ph);
         check("led", int'(LED), m_led);
         check("score", int'(score), m_score);
         check("best", int'(best), m_best);
         check("score_valid", int'(score_valid), m_valid);
         check("foul", int'(foul), m_foul);
      end
   end

   task automatic wait_phase(input int ph, input int budget, input string nm);
      int n = 0;
      while (int'(phase) != ph && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (int'(phase) != ph) begin
         bad++;
         $display("FAIL %s: phase %0d after %0d cycles, required %0d", nm, phase, n, ph);
      end
   endtask

   // Called on the first negedge of GO. mode 0 hit, 1 wrong single switch, 2 target+other.
   task automatic play_go(input int j, input int mode, input bit clr_same);
      int tg, w;
      tg = m_tg;
      repeat (j) @(negedge clk);
      w = (tg + 1 + int'($urandom_range(0, N - 2))) % N;
      case (mode)
         0:       SW = N'(1 << tg);
         1:       SW = N'(1 << w);
         default: SW = N'((1 << tg) | (1 << ((tg + 1) % N)));
      endcase
      repeat (2) @(negedge clk);
      if (clr_same) clr_best = 1'b1;
      @(negedge clk);
      clr_best = 1'b0;
      wait_phase(4, 20, "go_to_result");
   endtask

   int first_tg;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_led", int'(LED), 0);
      check("rst_score", int'(score), 0);
      check("rst_best", int'(best), 9999);
      check("rst_valid", int'(score_valid), 0);
      check("rst_foul", int'(foul), 0);
      check("rst_phase", int'(phase), 0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      wait_phase(2, 3, "arm_to_wait");
      check("wait_led", int'(LED), 0);
      wait_phase(3, 2000, "first_go");
      check("go_onehot", $countones(LED), 1);
      first_tg = m_tg;

      // GO entry at cycle 0; switch at cycle 146 is seen at cycle 148 -> 149/4 = 37 ticks
      play_go(146, 0, 1'b0);
      check("hit37_score", int'(score), 37);
      check("hit37_best", int'(best), 37);
      check("hit37_foul", int'(foul), 0);
      check("hit37_valid", int'(score_valid), 1);
      check("hit37_led", int'(LED), L_ALL);
      SW = '0;

      wait_phase(3, 2000, "go2");
      play_go(198, 0, 1'b0);
      check("hit50_score", int'(score), 50);
      check("hit50_best", int'(best), 37);
      SW = '0;

      // false start in WAIT, switch held through RESULT: must stay in ARM
      wait_phase(2, 2000, "wait3");
      repeat (2) @(negedge clk);
      SW = N'($urandom_range(1, L_ALL));
      wait_phase(4, 10, "false_start");
      check("fs_foul", int'(foul), 1);
      check("fs_score", int'(score), 9999);
      check("fs_best", int'(best), 37);
      check("fs_led", int'(LED), L_ALT);
      wait_phase(1, RH * TD + 20, "fs_to_arm");
      repeat (40) @(negedge clk);
      check("fs_hold_arm", int'(phase), 1);
      SW = '0;

      @(negedge clk);
      clr_best = 1'b1;
      @(negedge clk);
      clr_best = 1'b0;
      check("clr_best", int'(best), 9999);

      // hit with clr_best on the detect edge: clear wins, score 63/4 = 15
      wait_phase(3, 2000, "go_clr");
      play_go(60, 0, 1'b1);
      check("clrwin_score", int'(score), 15);
      check("clrwin_best", int'(best), 9999);
      SW = '0;

      wait_phase(3, 2000, "go_multi");
      play_go(20, 2, 1'b0);
      check("multi_foul", int'(foul), 1);
      check("multi_score", int'(score), 9999);
      SW = '0;

      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            clr_best = 1'b1;
            @(negedge clk);
            clr_best = 1'b0;
         end
         wait_phase(3, 2000, "rand_go");
         play_go(int'($urandom_range(0, 400)), int'($urandom_range(0, 2)), 1'b0);
         SW = '0;
      end

      wait_phase(3, 2000, "sat_go");
      wait_phase(4, MAXS * TD + 20, "sat_result");
      check("sat_foul", int'(foul), 1);
      check("sat_score", int'(score), 9999);

      wait_phase(3, 2000, "rst_go");
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_led", int'(LED), 0);
      check("arst_score", int'(score), 0);
      check("arst_best", int'(best), 9999);
      check("arst_valid", int'(score_valid), 0);
      check("arst_foul", int'(foul), 0);
      check("arst_phase", int'(phase), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_phase(3, 2000, "post_rst_go");
      check("same_target", int'(LED), 1 << first_tg);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
